hamming_ext_byte_assembler: RTL and testbench

//  Downstream stage of the extended Hamming (8,4) decoder. Accepts one decoded nibble plus its

---
 rtl/hamming_ext_byte_assembler.sv | 106 ++++++++++
 tb/tb_hamming_ext_byte_assembler.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/hamming_ext_byte_assembler.sv
// hamming_ext_byte_assembler: pairs decoded Hamming nibbles into bytes with error flags and saturating counters
module hamming_ext_byte_assembler #(
  parameter bit HI_FIRST    = 1'b0,
  parameter bit DROP_UNCORR = 1'b0,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  input  logic             in_corr,
  input  logic             in_uncorr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_corr,
  output logic             out_uncorr,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt,
  output logic [CNT_W-1:0] drop_cnt
);
  typedef enum logic {S_FIRST, S_SECOND} state_t;
  state_t           state_q, state_d;
  logic [3:0]       hold_data_q, hold_data_d;
  logic             hold_corr_q, hold_corr_d;
  logic             hold_uncorr_q, hold_uncorr_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_corr_q, out_corr_d;
  logic             out_uncorr_q, out_uncorr_d;
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             acc, nib_corr, form, load, drop_inc, pair_corr, pair_uncorr;
  logic [7:0]       pair_data;

  // Clear takes priority but still lets a same-cycle event land as a count of one.
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] cnt, input logic clr, input logic inc);
    return clr ? CNT_W'(inc) : (inc && !(&cnt)) ? cnt + CNT_W'(1) : cnt;
  endfunction

  assign in_ready = (state_q == S_FIRST) || !out_valid_q || out_ready;

  // Pairing, drop decision, output register hand-off and counter updates.
  always_comb begin
    acc           = in_valid && in_ready;
    nib_corr      = in_corr && !in_uncorr;
    form          = acc && (state_q == S_SECOND) && !flush;
    pair_data     = HI_FIRST ? {hold_data_q, in_data} : {in_data, hold_data_q};
    pair_corr     = hold_corr_q || nib_corr;
    pair_uncorr   = hold_uncorr_q || in_uncorr;
    load          = form && !(DROP_UNCORR && pair_uncorr);
    drop_inc      = (flush && (state_q == S_SECOND)) || (form && !load);
    state_d       = (state_q == S_FIRST) ? (acc ? S_SECOND : S_FIRST) : ((acc || flush) ? S_FIRST : S_SECOND);
    hold_data_d   = (acc && state_q == S_FIRST) ? in_data : hold_data_q;
    hold_corr_d   = (acc && state_q == S_FIRST) ? nib_corr : hold_corr_q;
    hold_uncorr_d = (acc && state_q == S_FIRST) ? in_uncorr : hold_uncorr_q;
    out_valid_d   = load || (out_valid_q && !out_ready);
    out_data_d    = load ? pair_data : out_data_q;
    out_corr_d    = load ? pair_corr : out_corr_q;
    out_uncorr_d  = load ? pair_uncorr : out_uncorr_q;
    corr_cnt_d    = bump(corr_cnt_q, cnt_clr, acc && nib_corr);
    uncorr_cnt_d  = bump(uncorr_cnt_q, cnt_clr, acc && in_uncorr);
    drop_cnt_d    = bump(drop_cnt_q, cnt_clr, drop_inc);
  end

  // State, holding and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FIRST;
      hold_data_q   <= '0;
      hold_corr_q   <= 1'b0;
      hold_uncorr_q <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_corr_q    <= 1'b0;
      out_uncorr_q  <= 1'b0;
      corr_cnt_q    <= '0;
      uncorr_cnt_q  <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      hold_data_q   <= hold_data_d;
      hold_corr_q   <= hold_corr_d;
      hold_uncorr_q <= hold_uncorr_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_corr_q    <= out_corr_d;
      out_uncorr_q  <= out_uncorr_d;
      corr_cnt_q    <= corr_cnt_d;
      uncorr_cnt_q  <= uncorr_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_corr   = out_corr_q;
  assign out_uncorr = out_uncorr_q;
  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;
  assign drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_hamming_ext_byte_assembler.sv
// tb_hamming_ext_byte_assembler: three parameterisations driven in lockstep against a pairing reference model
module tb_hamming_ext_byte_assembler;
  localparam int NI = 3;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_corr = 1'b0, in_uncorr = 1'b0, flush = 1'b0, out_ready = 1'b0, cnt_clr = 1'b0;
  logic [3:0] in_data = '0;
  logic rdy[NI], ov[NI], oc[NI], ou[NI];
  logic [7:0] od[NI];
  logic [15:0] cc0, uc0, dc0, cc2, uc2, dc2;
  logic [1:0] cc1, uc1, dc1;

  always #5 clk = ~clk;

  hamming_ext_byte_assembler #(.HI_FIRST(1'b0), .DROP_UNCORR(1'b0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
    .in_corr(in_corr), .in_uncorr(in_uncorr), .flush(flush), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .out_corr(oc[0]), .out_uncorr(ou[0]), .cnt_clr(cnt_clr),
    .corr_cnt(cc0), .uncorr_cnt(uc0), .drop_cnt(dc0));
  hamming_ext_byte_assembler #(.HI_FIRST(1'b0), .DROP_UNCORR(1'b1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
    .in_corr(in_corr), .in_uncorr(in_uncorr), .flush(flush), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .out_corr(oc[1]), .out_uncorr(ou[1]), .cnt_clr(cnt_clr),
    .corr_cnt(cc1), .uncorr_cnt(uc1), .drop_cnt(dc1));
  hamming_ext_byte_assembler #(.HI_FIRST(1'b1), .DROP_UNCORR(1'b0), .CNT_W(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_data),
    .in_corr(in_corr), .in_uncorr(in_uncorr), .flush(flush), .out_valid(ov[2]), .out_ready(out_ready),
    .out_data(od[2]), .out_corr(oc[2]), .out_uncorr(ou[2]), .cnt_clr(cnt_clr),
    .corr_cnt(cc2), .uncorr_cnt(uc2), .drop_cnt(dc2));

  int n_cmp = 0, n_err = 0;
  int mx[NI] = '{65535, 3, 65535};
  bit hi[NI] = '{1'b0, 1'b0, 1'b1};
  bit dr[NI] = '{1'b0, 1'b1, 1'b0};
  int m_half[NI], m_hd[NI], m_hc[NI], m_hu[NI], m_ov[NI], m_od[NI], m_oc[NI], m_ou[NI];
  int m_cc[NI], m_uc[NI], m_dc[NI];
  bit rdy_obs[NI];
  int bytes, bubbles;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int x, input int inc, input int m);
    return (x + inc > m) ? m : x + inc;
  endfunction

  function automatic logic [15:0] cnt_of(input int k, input int w);
    logic [15:0] c [3][3];
    c = '{'{cc0, uc0, dc0}, '{16'(cc1), 16'(uc1), 16'(dc1)}, '{cc2, uc2, dc2}};
    return c[k][w];
  endfunction

  task automatic check_outs();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("out_valid%0d", k), ov[k], m_ov[k]);
      if (m_ov[k] != 0) begin
        chk($sformatf("out_data%0d", k), od[k], m_od[k]);
        chk($sformatf("out_corr%0d", k), oc[k], m_oc[k]);
        chk($sformatf("out_uncorr%0d", k), ou[k], m_ou[k]);
      end
      chk($sformatf("corr_cnt%0d", k), cnt_of(k, 0), m_cc[k]);
      chk($sformatf("uncorr_cnt%0d", k), cnt_of(k, 1), m_uc[k]);
      chk($sformatf("drop_cnt%0d", k), cnt_of(k, 2), m_dc[k]);
    end
  endtask

  task automatic step(input bit v, input bit [3:0] d, input bit c, input bit u, input bit f, input bit r, input bit clr);
    bit acc[NI];
    in_valid = v; in_data = d; in_corr = c; in_uncorr = u; flush = f; out_ready = r; cnt_clr = clr;
    #1;
    for (int k = 0; k < NI; k++) begin
      bit er;
      er = (m_half[k] == 0) || (m_ov[k] == 0) || r;
      rdy_obs[k] = rdy[k];
      chk($sformatf("in_ready%0d", k), rdy[k], er);
      acc[k] = v && er;
    end
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      int dinc;
      bit ec;
      dinc = 0;
      ec = c && !u;
      if (m_ov[k] != 0 && r) m_ov[k] = 0;
      if (acc[k]) begin
        if (m_half[k] == 0) begin
          m_half[k] = 1; m_hd[k] = d; m_hc[k] = ec; m_hu[k] = u;
        end else if (f) begin
          m_half[k] = 0; dinc = 1;
        end else begin
          m_half[k] = 0;
          if (dr[k] && (m_hu[k] != 0 || u)) dinc = 1;
          else begin
            m_ov[k] = 1;
            m_od[k] = hi[k] ? m_hd[k] * 16 + d : d * 16 + m_hd[k];
            m_oc[k] = (m_hc[k] != 0 || ec) ? 1 : 0;
            m_ou[k] = (m_hu[k] != 0 || u) ? 1 : 0;
          end
        end
      end else if (f && m_half[k] != 0) begin
        m_half[k] = 0; dinc = 1;
      end
      m_cc[k] = sat(clr ? 0 : m_cc[k], (acc[k] && ec) ? 1 : 0, mx[k]);
      m_uc[k] = sat(clr ? 0 : m_uc[k], (acc[k] && u) ? 1 : 0, mx[k]);
      m_dc[k] = sat(clr ? 0 : m_dc[k], dinc, mx[k]);
    end
    @(negedge clk);
    check_outs();
  endtask

  task automatic do_reset();
    in_valid = 0; in_corr = 0; in_uncorr = 0; flush = 0; out_ready = 0; cnt_clr = 0; in_data = 0;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst_in_ready%0d", k), rdy[k], 1);
      chk($sformatf("rst_out_valid%0d", k), ov[k], 0);
      chk($sformatf("rst_out_data%0d", k), od[k], 0);
      chk($sformatf("rst_flags%0d", k), {oc[k], ou[k]}, 0);
      chk($sformatf("rst_cnts%0d", k), cnt_of(k, 0) | cnt_of(k, 1) | cnt_of(k, 2), 0);
      m_half[k] = 0; m_hd[k] = 0; m_hc[k] = 0; m_hu[k] = 0; m_ov[k] = 0; m_od[k] = 0;
      m_oc[k] = 0; m_ou[k] = 0; m_cc[k] = 0; m_uc[k] = 0; m_dc[k] = 0;
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    step(1, 4'h5, 0, 0, 0, 1, 0);
    chk("t1_no_early_valid", ov[0], 0);
    step(1, 4'hA, 0, 0, 0, 1, 0);
    chk("t1_valid", ov[0], 1);
    chk("t1_data", od[0], 8'hA5);
    chk("t1_corr", oc[0], 0);
    chk("t1_hi_first_data", od[2], 8'h5A);
    step(1, 4'h3, 1, 0, 0, 1, 0);
    step(1, 4'hC, 0, 0, 0, 0, 0);
    chk("t2_data", od[0], 8'hC3);
    chk("t2_corr", oc[0], 1);
    repeat (5) step(0, 4'h0, 0, 0, 0, 0, 0);
    chk("t2_held_valid", ov[0], 1);
    chk("t2_held_data", od[0], 8'hC3);
    chk("t2_corr_cnt", cc0, 1);
    step(1, 4'h7, 0, 0, 0, 0, 0);
    chk("t2_third_accepted", rdy_obs[0], 1);
    step(1, 4'h9, 0, 0, 0, 0, 0);
    chk("t2_fourth_stalled", rdy_obs[0], 0);
    step(1, 4'h9, 0, 0, 0, 1, 0);
    chk("t2_fourth_accepted", rdy_obs[0], 1);
    chk("t2_reload_data", od[0], 8'h97);
    step(0, 4'h0, 0, 0, 0, 1, 0);

    do_reset();
    step(1, 4'h1, 0, 0, 0, 1, 0);
    step(1, 4'h2, 0, 1, 0, 1, 0);
    chk("t3_dropped_valid", ov[1], 0);
    chk("t3_drop_cnt", dc1, 1);
    chk("t3_uncorr_cnt", uc1, 1);
    chk("t3_kept_uncorr", ou[0], 1);
    step(1, 4'h4, 0, 0, 0, 1, 0);
    step(1, 4'h8, 0, 0, 0, 1, 0);
    chk("t3_next_valid", ov[1], 1);
    chk("t3_next_data", od[1], 8'h84);

    do_reset();
    step(1, 4'h7, 0, 0, 0, 1, 0);
    step(0, 4'h0, 0, 0, 1, 1, 0);
    step(1, 4'h1, 0, 0, 0, 1, 0);
    step(1, 4'h2, 0, 0, 0, 1, 0);
    chk("t4_data", od[0], 8'h21);
    chk("t4_drop_cnt", dc0, 1);

    do_reset();
    repeat (5) step(1, 4'($urandom), 1, 0, 0, 1, 0);
    chk("t5_sat", cc1, 3);
    chk("t5_wide", cc0, 5);
    step(1, 4'h6, 1, 0, 0, 1, 1);
    chk("t5_clr_inc", cc1, 1);

    do_reset();
    bytes = 0; bubbles = 0;
    for (int i = 0; i < 65; i++) begin
      step(i < 64, 4'($urandom), 0, 0, 0, 1, 0);
      if (ov[0]) bytes++;
      if (i < 64 && !rdy_obs[0]) bubbles++;
    end
    chk("t6_bytes", bytes, 32);
    chk("t6_bubbles", bubbles, 0);
    repeat (5) step(1, 4'($urandom), 1, 0, 0, 0, 0);
    do_reset();

    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      step($urandom_range(0, 9) < 7, 4'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
